md_unit: RTL

Multiply/divide unit in the EX stage of the P7 pipeline. It executes mult/multu/div/divu with fixed multi-cycle latency and owns the architectural HI/LO registers. It services mthi/mtlo/mfhi/mflo and drives `E_hiloData`, which the EX/MEM pipeline register latches. The hazard unit consumes `start`/`busy` to stall md-type instructions in D.

---
 rtl/md_unit_pkg.sv | 36 +++
 rtl/md_calc.sv | 46 ++++
 rtl/md_unit.sv | 74 +++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder that emits E_mdOp.
package md_unit_pkg;

  localparam int unsigned MD_OP_W        = 4;
  localparam int unsigned MD_DATA_W      = 32;
  localparam int unsigned MD_CNT_W       = 4;
  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef struct packed {
    logic [MD_DATA_W-1:0] hi;
    logic [MD_DATA_W-1:0] lo;
    logic                 dz;
  } md_result_t;

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_start(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational mult/div datapath: (op, rs, rt) -> {hi, lo, dz}.
module md_calc
  import md_unit_pkg::*;
(
  input  logic [MD_OP_W-1:0]   op,
  input  logic [MD_DATA_W-1:0] rs,
  input  logic [MD_DATA_W-1:0] rt,
  output md_result_t           res
);

  logic [2*MD_DATA_W-1:0] prod_s;
  logic [2*MD_DATA_W-1:0] prod_u;
  logic                   neg_a;
  logic                   neg_b;
  logic [MD_DATA_W-1:0]   mag_a;
  logic [MD_DATA_W-1:0]   mag_b;
  logic [MD_DATA_W-1:0]   divisor;
  logic [MD_DATA_W-1:0]   quo;
  logic [MD_DATA_W-1:0]   rem;

  // Signed divide works on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
  always_comb begin
    prod_s  = {{MD_DATA_W{rs[MD_DATA_W-1]}}, rs} * {{MD_DATA_W{rt[MD_DATA_W-1]}}, rt};
    prod_u  = {{MD_DATA_W{1'b0}}, rs} * {{MD_DATA_W{1'b0}}, rt};
    neg_a   = (op == MD_DIV) && rs[MD_DATA_W-1];
    neg_b   = (op == MD_DIV) && rt[MD_DATA_W-1];
    mag_a   = neg_a ? (~rs + MD_DATA_W'(1)) : rs;
    mag_b   = neg_b ? (~rt + MD_DATA_W'(1)) : rt;
    divisor = (rt == '0) ? MD_DATA_W'(1) : mag_b;
    quo     = mag_a / divisor;
    rem     = mag_a % divisor;

    res    = '0;
    res.dz = md_is_div(op) && (rt == '0);
    case (op)
      MD_MULT:  {res.hi, res.lo} = prod_s;
      MD_MULTU: {res.hi, res.lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        res.lo = (neg_a ^ neg_b) ? (~quo + MD_DATA_W'(1)) : quo;
        res.hi = neg_a ? (~rem + MD_DATA_W'(1)) : rem;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: fixed-latency mult/div, owns HI/LO, services mt*/mf*.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MD_OP_W-1:0]   E_mdOp,
  input  logic [MD_DATA_W-1:0] E_rsData,
  input  logic [MD_DATA_W-1:0] E_rtData,
  input  logic                 flush,
  output logic                 start,
  output logic                 busy,
  output logic [MD_DATA_W-1:0] E_hiloData
);

  logic [MD_CNT_W-1:0]  cnt;
  logic [MD_DATA_W-1:0] hi;
  logic [MD_DATA_W-1:0] lo;
  logic [MD_DATA_W-1:0] hi_tmp;
  logic [MD_DATA_W-1:0] lo_tmp;
  logic                 dz_tmp;
  md_result_t           calc;

  md_calc u_calc (
    .op  (E_mdOp),
    .rs  (E_rsData),
    .rt  (E_rtData),
    .res (calc)
  );

  assign busy  = (cnt != '0);
  assign start = md_is_start(E_mdOp) && !busy && !flush;

  always_comb begin
    E_hiloData = '0;
    if (E_mdOp == MD_MFHI) E_hiloData = hi;
    else if (E_mdOp == MD_MFLO) E_hiloData = lo;
  end

  // Result is latched at issue and committed on the last busy edge; divide-by-zero leaves HI/LO alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      hi_tmp <= '0;
      lo_tmp <= '0;
      dz_tmp <= 1'b0;
    end else begin
      if (start) begin
        hi_tmp <= calc.hi;
        lo_tmp <= calc.lo;
        dz_tmp <= calc.dz;
        cnt    <= md_is_div(E_mdOp) ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
      end else if (busy) begin
        cnt <= cnt - MD_CNT_W'(1);
      end

      if (busy) begin
        if ((cnt == MD_CNT_W'(1)) && !dz_tmp) begin
          hi <= hi_tmp;
          lo <= lo_tmp;
        end
      end else if (!flush) begin
        if (E_mdOp == MD_MTHI) hi <= E_rsData;
        if (E_mdOp == MD_MTLO) lo <= E_rsData;
      end
    end
  end

endmodule
